// File: rtl/sbc_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sbc_bus_ctrl_if
// Brief    : CPU-side bus and device-select signals of the SBC bus controller.
// Revision : 1.0
// ============================================================================
interface sbc_bus_ctrl_if;
    logic        phi2;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic        err_clr;
    logic        rom_cs_n;
    logic        ram_cs_n;
    logic        acia1_cs_n;
    logic [1:0]  acia1_rs;
    logic        rd_stb;
    logic        wr_stb;
    logic        rdy;
    logic        bus_err;

    modport master (
        output phi2, cpu_addr, cpu_rw, err_clr,
        input  rom_cs_n, ram_cs_n, acia1_cs_n, acia1_rs, rd_stb, wr_stb, rdy, bus_err
    );

    modport slave (
        input  phi2, cpu_addr, cpu_rw, err_clr,
        output rom_cs_n, ram_cs_n, acia1_cs_n, acia1_rs, rd_stb, wr_stb, rdy, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/sbc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sbc_bus_ctrl
// Brief    : 6502-style bus cycle controller: phi2 sampling, address decode,
//            per-region wait states, device strobes and early-abort flag.
// Revision : 1.0
// ============================================================================
module sbc_bus_ctrl #(
    parameter int unsigned RAM_WS     = 0,
    parameter int unsigned ROM_WS     = 1,
    parameter int unsigned ACIA_WS    = 3,
    parameter logic [15:0] ACIA1_BASE = 16'h8400,
    parameter logic [15:0] ROM_BASE   = 16'hC000
) (
    input  logic            fst_clk,
    input  logic            res_n,
    sbc_bus_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    // Chip-select vector order: {acia1, ram, rom}, active low
    localparam logic [2:0] c_CS_NONE = 3'b111;
    localparam logic [2:0] c_CS_ROM  = 3'b110;
    localparam logic [2:0] c_CS_RAM  = 3'b101;
    localparam logic [2:0] c_CS_ACIA = 3'b011;
    localparam logic [3:0] c_RAM_WS  = 4'(RAM_WS);
    localparam logic [3:0] c_ROM_WS  = 4'(ROM_WS);
    localparam logic [3:0] c_ACIA_WS = 4'(ACIA_WS);

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_cs_n, w_cs_nxt;
    logic       r_phi2_meta, r_phi2_s, r_phi2_d;
    logic [1:0] r_warm;
    logic       r_armed;
    logic       r_rw;
    logic [1:0] r_rs;
    logic       r_rdy, w_rdy_nxt;
    logic       r_rd_stb, r_wr_stb, w_rd_nxt, w_wr_nxt;
    logic       r_bus_err, w_err_set;
    logic       w_latch;
    logic       w_rise, w_fall, w_fall_next;
    logic       w_hit_ram, w_hit_acia, w_hit_rom;

    // A phi2 already high when reset lifts must be seen low once before any rise counts
    assign w_rise      = r_armed & r_phi2_s & ~r_phi2_d;
    assign w_fall      = ~r_phi2_s & r_phi2_d;
    // The fall that will be detected next cycle, used to cancel a strobe due in DONE
    assign w_fall_next = ~r_phi2_meta & r_phi2_s;

    // Decode feeds the select flops in parallel with the address latch
    assign w_hit_ram  = (bus.cpu_addr < 16'h8000);
    assign w_hit_acia = (bus.cpu_addr[15:2] == ACIA1_BASE[15:2]);
    assign w_hit_rom  = (bus.cpu_addr >= ROM_BASE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cs_nxt    = r_cs_n;
        w_rd_nxt    = 1'b0;
        w_wr_nxt    = 1'b0;
        w_err_set   = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cs_nxt = c_CS_NONE;
                if (w_rise) begin
                    w_latch = 1'b1;
                    if (w_hit_ram) begin
                        w_state_nxt = ST_ACCESS;
                        w_cs_nxt    = c_CS_RAM;
                        w_cnt_nxt   = c_RAM_WS;
                    end else if (w_hit_acia) begin
                        w_state_nxt = ST_ACCESS;
                        w_cs_nxt    = c_CS_ACIA;
                        w_cnt_nxt   = c_ACIA_WS;
                    end else if (w_hit_rom) begin
                        w_state_nxt = ST_ACCESS;
                        w_cs_nxt    = c_CS_ROM;
                        w_cnt_nxt   = c_ROM_WS;
                    end else begin
                        w_state_nxt = ST_WAIT_LOW;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_cs_nxt    = c_CS_NONE;
                    w_err_set   = 1'b1;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    w_state_nxt = ST_DONE;
                    w_rd_nxt    = r_rw & ~w_fall_next;
                    w_wr_nxt    = ~r_rw & ~w_fall_next;
                end
            end
            ST_DONE: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_cs_nxt    = c_CS_NONE;
                    w_err_set   = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_LOW;
                end
            end
            default: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_cs_nxt    = c_CS_NONE;
                end
            end
        endcase
        w_rdy_nxt = ~((w_state_nxt == ST_ACCESS) && (w_cnt_nxt != 4'd0));
    end

    always_ff @(posedge fst_clk or negedge res_n) begin
        if (!res_n) begin
            r_phi2_meta <= 1'b0;
            r_phi2_s    <= 1'b0;
            r_phi2_d    <= 1'b0;
            r_warm      <= 2'b00;
            r_armed     <= 1'b0;
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_cs_n      <= c_CS_NONE;
            r_rw        <= 1'b1;
            r_rs        <= 2'b00;
            r_rdy       <= 1'b1;
            r_rd_stb    <= 1'b0;
            r_wr_stb    <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_phi2_meta <= bus.phi2;
            r_phi2_s    <= r_phi2_meta;
            r_phi2_d    <= r_phi2_s;
            r_warm      <= {r_warm[0], 1'b1};
            if (r_warm[1] && !r_phi2_s) begin
                r_armed <= 1'b1;
            end
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cs_n   <= w_cs_nxt;
            r_rdy    <= w_rdy_nxt;
            r_rd_stb <= w_rd_nxt;
            r_wr_stb <= w_wr_nxt;
            if (w_latch) begin
                r_rw <= bus.cpu_rw;
                r_rs <= bus.cpu_addr[1:0];
            end
            if (w_err_set) begin
                r_bus_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign bus.acia1_cs_n = r_cs_n[2];
    assign bus.ram_cs_n   = r_cs_n[1];
    assign bus.rom_cs_n   = r_cs_n[0];
    assign bus.acia1_rs   = r_rs;
    assign bus.rd_stb     = r_rd_stb;
    assign bus.wr_stb     = r_wr_stb;
    assign bus.rdy        = r_rdy;
    assign bus.bus_err    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_sbc_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbc_bus_ctrl
// Brief    : Self-checking bench for sbc_bus_ctrl against a cycle-offset model.
// Revision : 1.0
// ============================================================================
module tb_sbc_bus_ctrl;

    logic fst_clk = 1'b0;
    logic res_n   = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    logic       m_err = 1'b0;
    logic [1:0] m_rs  = 2'b00;

    sbc_bus_ctrl_if bus();

    sbc_bus_ctrl #(
        .RAM_WS     (0),
        .ROM_WS     (1),
        .ACIA_WS    (3),
        .ACIA1_BASE (16'h8400),
        .ROM_BASE   (16'hC000)
    ) dut (
        .fst_clk (fst_clk),
        .res_n   (res_n),
        .bus     (bus)
    );

    always #5 fst_clk = ~fst_clk;

    // Region: 0 unmapped, 1 RAM, 2 ACIA1, 3 ROM
    function automatic int region_of(input logic [15:0] a);
        if (a <= 16'h7FFF) return 1;
        if (a >= 16'h8400 && a <= 16'h8403) return 2;
        if (a >= 16'hC000) return 3;
        return 0;
    endfunction

    function automatic int ws_of(input int r);
        case (r)
            1: return 0;
            2: return 3;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    // One phi2 period: high for h fst_clk edges, low for l more. Offset n counts
    // cycles from the rise-detect cycle; the fall is detected at n == h.
    task automatic drive_bus_cycle(input logic [15:0] addr, input logic rw, input int h,
                                   input int l, input int clr_n, input string tag);
        int   reg_id, ws, n;
        bit   mapped, abort, clr_prev;
        logic e_ram, e_rom, e_acia, e_rdy, e_rd, e_wr;
        reg_id   = region_of(addr);
        ws       = ws_of(reg_id);
        mapped   = (reg_id != 0);
        abort    = mapped && (h <= ws + 2);
        clr_prev = 1'b0;
        bus.cpu_addr = addr;
        bus.cpu_rw   = rw;
        bus.err_clr  = 1'b0;
        bus.phi2     = 1'b1;
        for (int j = 1; j <= h + 2 + l; j++) begin
            n = j - 2;
            @(negedge fst_clk);
            if (n == 1) m_rs = addr[1:0];
            if (abort && n == h + 1) m_err = 1'b1;
            else if (clr_prev) m_err = 1'b0;
            e_ram  = !(reg_id == 1 && n >= 1 && n <= h);
            e_acia = !(reg_id == 2 && n >= 1 && n <= h);
            e_rom  = !(reg_id == 3 && n >= 1 && n <= h);
            e_rdy  = !(mapped && n >= 1 && n <= ws && n <= h);
            e_rd   = mapped && !abort && rw && (n == ws + 2);
            e_wr   = mapped && !abort && !rw && (n == ws + 2);
            checks++;
            if (bus.ram_cs_n !== e_ram) begin
                failures++;
                $display("FAIL %s ram_cs_n addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.ram_cs_n, e_ram);
            end
            checks++;
            if (bus.acia1_cs_n !== e_acia) begin
                failures++;
                $display("FAIL %s acia1_cs_n addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.acia1_cs_n, e_acia);
            end
            checks++;
            if (bus.rom_cs_n !== e_rom) begin
                failures++;
                $display("FAIL %s rom_cs_n addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.rom_cs_n, e_rom);
            end
            checks++;
            if (bus.rdy !== e_rdy) begin
                failures++;
                $display("FAIL %s rdy addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.rdy, e_rdy);
            end
            checks++;
            if (bus.rd_stb !== e_rd) begin
                failures++;
                $display("FAIL %s rd_stb addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.rd_stb, e_rd);
            end
            checks++;
            if (bus.wr_stb !== e_wr) begin
                failures++;
                $display("FAIL %s wr_stb addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.wr_stb, e_wr);
            end
            checks++;
            if (bus.bus_err !== m_err) begin
                failures++;
                $display("FAIL %s bus_err addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.bus_err, m_err);
            end
            checks++;
            if (bus.acia1_rs !== m_rs) begin
                failures++;
                $display("FAIL %s acia1_rs addr=%h n=%0d got=%b exp=%b", tag, addr, n, bus.acia1_rs, m_rs);
            end
            clr_prev    = (n == clr_n);
            bus.err_clr = clr_prev;
            if (j == h) bus.phi2 = 1'b0;
        end
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        bus.phi2 = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_rw = 1'b1; bus.err_clr = 1'b0;
        res_n = 1'b0;
        repeat (3) @(negedge fst_clk);
        got = {bus.rom_cs_n, bus.ram_cs_n, bus.acia1_cs_n, bus.acia1_rs, bus.rd_stb, bus.wr_stb, bus.rdy, bus.bus_err, 1'b0};
        checks++;
        if (got !== 10'b111_00_00_1_0_0) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", got, 10'b1110000100);
        end
        res_n = 1'b1;
        repeat (6) @(negedge fst_clk);
        got = {bus.rom_cs_n, bus.ram_cs_n, bus.acia1_cs_n, bus.acia1_rs, bus.rd_stb, bus.wr_stb, bus.rdy, bus.bus_err, 1'b0};
        checks++;
        if (got !== 10'b111_00_00_1_0_0) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=%b", got, 10'b1110000100);
        end
    endtask

    task automatic test_ram_read();
        drive_bus_cycle(16'h1234, 1'b1, 10, 4, -100, "ram_read");
    endtask

    task automatic test_acia_write();
        drive_bus_cycle(16'h8402, 1'b0, 10, 4, -100, "acia_write");
    endtask

    task automatic test_decode_boundaries();
        logic [15:0] addrs [8];
        addrs = '{16'hBFFF, 16'hC000, 16'h8403, 16'h8404, 16'h7FFF, 16'h8400, 16'hFFFF, 16'h8000};
        for (int i = 0; i < 8; i++) begin
            drive_bus_cycle(addrs[i], i[0], 9, 3, -100, "decode");
        end
    endtask

    task automatic test_early_abort();
        drive_bus_cycle(16'h8401, 1'b1, 2, 3, -100, "abort_access");
        drive_bus_cycle(16'hA000, 1'b1, 3, 3, 1, "err_clr");
        drive_bus_cycle(16'h8402, 1'b0, 2, 3, 2, "abort_with_clr");
        drive_bus_cycle(16'h9000, 1'b1, 3, 3, 0, "err_clr2");
        drive_bus_cycle(16'h8403, 1'b1, 5, 3, -100, "abort_in_done");
        drive_bus_cycle(16'hC123, 1'b0, 2, 3, 5, "abort_access_cnt0");
        drive_bus_cycle(16'h0000, 1'b1, 2, 3, 4, "ram_abort_done");
    endtask

    task automatic test_reset_mid();
        logic [9:0] got;
        bus.cpu_addr = 16'h8401; bus.cpu_rw = 1'b1; bus.err_clr = 1'b0; bus.phi2 = 1'b1;
        repeat (4) @(negedge fst_clk);
        checks++;
        if ({bus.acia1_cs_n, bus.rdy} !== 2'b00) begin
            failures++;
            $display("FAIL mid_access_before_reset got=%b exp=00", {bus.acia1_cs_n, bus.rdy});
        end
        #2 res_n = 1'b0;
        #1;
        m_err = 1'b0;
        m_rs  = 2'b00;
        got = {bus.rom_cs_n, bus.ram_cs_n, bus.acia1_cs_n, bus.acia1_rs, bus.rd_stb, bus.wr_stb, bus.rdy, bus.bus_err, 1'b0};
        checks++;
        if (got !== 10'b111_00_00_1_0_0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=%b", got, 10'b1110000100);
        end
        @(negedge fst_clk);
        res_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge fst_clk);
            got = {bus.rom_cs_n, bus.ram_cs_n, bus.acia1_cs_n, bus.acia1_rs, bus.rd_stb, bus.wr_stb, bus.rdy, bus.bus_err, 1'b0};
            checks++;
            if (got !== 10'b111_00_00_1_0_0) begin
                failures++;
                $display("FAIL no_access_phi2_high k=%0d got=%b exp=%b", k, got, 10'b1110000100);
            end
        end
        bus.phi2 = 1'b0;
        repeat (4) @(negedge fst_clk);
        drive_bus_cycle(16'h8401, 1'b1, 8, 3, -100, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        int sel;
        for (int i = 0; i < 20; i++) begin
            sel = i % 3;
            if (sel == 0)      a = 16'($urandom_range(0, 16'h7FFF));
            else if (sel == 1) a = 16'hC000 + 16'($urandom_range(0, 16'h3FFF));
            else               a = 16'h8400 + 16'($urandom_range(0, 3));
            drive_bus_cycle(a, 1'($urandom_range(0, 1)), ws_of(region_of(a)) + 3 + int'($urandom_range(0, 4)),
                            int'($urandom_range(2, 4)), -100, "back_to_back");
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = 16'h8400 | 16'($urandom_range(0, 3));
            drive_bus_cycle(a, 1'($urandom_range(0, 1)), int'($urandom_range(1, 9)), int'($urandom_range(2, 4)),
                            int'($urandom_range(0, 12)) - 2, "random");
        end
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_acia_write();
        test_decode_boundaries();
        test_early_abort();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
